// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Self-checking truth-table engine for an external N-input logic gate.
//   It drives every input combination in turn, waits SETTLE cycles, samples
//   the gate output and compares it with an internally computed golden value.
//
// Parameters
//   N       number of gate inputs (1..8)
//   SETTLE  cycles each vector is held before it is sampled (>= 1)
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   start            begin a sweep (accepted only in IDLE or DONE)
//   op               golden function, latched at start:
//                    0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 NOR
//   dut_s            output of the gate under test
//   vec              registered input vector driven to the gate
//   exp_s            golden value for vec and the latched op
//   busy             sweep in progress
//   done             sweep finished, held until the next accepted start
//   pass             valid while done: no mismatches recorded
//   err_count        mismatch count for the current or last sweep
//   first_err_valid  at least one mismatch recorded
//   first_err_vec    vector of the first mismatch
//
// States
//   IDLE  | waiting for start after reset
//   DRIVE | vec held stable while the gate settles
//   CHECK | one cycle: compare dut_s with exp_s, advance or finish
//   DONE  | results held until the next start
module gate_sweep_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         dut_s,
    output logic [N-1:0] vec,
    output logic         exp_s,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_err_valid,
    output logic [N-1:0] first_err_vec
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [2:0]    op_q;
    logic          accept;
    logic          settled;
    logic          last_vec;
    logic          mismatch;
    logic [N:0]    err_next;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign settled  = (settle_cnt == SW'(SETTLE - 1));
    assign last_vec = &vec;
    assign mismatch = (state == CHECK) && (dut_s != exp_s);
    assign err_next = err_count + (N+1)'(mismatch);

    always_comb begin
        exp_s = 1'b0;
        case (op_q)
            3'd0:    exp_s =  (&vec);
            3'd1:    exp_s =  (|vec);
            3'd2:    exp_s = ~(&vec);
            3'd3:    exp_s = ~(|vec);
            3'd4:    exp_s =  (^vec);
            3'd5:    exp_s = ~(^vec);
            default: exp_s = ~(|vec);
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = DRIVE;
            DRIVE:   if (settled)  state_nxt = CHECK;
            CHECK:   state_nxt = last_vec ? DONE : DRIVE;
            DONE:    if (accept)   state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec             <= '0;
            settle_cnt      <= '0;
            op_q            <= 3'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (accept) begin
            op_q            <= op;
            vec             <= '0;
            settle_cnt      <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (state == DRIVE) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else if (state == CHECK) begin
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= vec;
            end
            // Termination keys off the all-ones vector so vec never wraps.
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next == '0);
            end else begin
                vec        <= vec + N'(1);
                settle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

    typedef struct packed {
        logic [7:0] vec;
        logic       exp_s;
        logic       busy;
        logic       done;
        logic       pass;
        logic [8:0] err;
        logic       fvalid;
        logic [7:0] fvec;
    } obs_t;

    typedef struct {
        logic [7:0] v;
        logic       e;
        logic [8:0] err;
        logic       fvalid;
    } step_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Instance A: N=2 SETTLE=1, B: N=3 SETTLE=1, C: N=2 SETTLE=3
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [2:0] op_a = 3'd0, op_b = 3'd0, op_c = 3'd0;
    int         gate_a = 0, gate_b = 0, gate_c = 0;
    logic       dut_s_a, dut_s_b, dut_s_c;

    logic [1:0] vec_a, fvec_a;
    logic [2:0] vec_b, fvec_b;
    logic [1:0] vec_c, fvec_c;
    logic [2:0] err_a;
    logic [3:0] err_b;
    logic [2:0] err_c;
    logic exp_a, busy_a, done_a, pass_a, fval_a;
    logic exp_b, busy_b, done_b, pass_b, fval_b;
    logic exp_c, busy_c, done_c, pass_c, fval_c;

    // Golden reference: explicit bit loop over the low n bits.
    function automatic logic gold(input int f, input logic [7:0] v, input int n);
        logic a, o, x;
        a = 1'b1; o = 1'b0; x = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a & v[i];
            o = o | v[i];
            x = x ^ v[i];
        end
        case (f)
            0: return a;
            1: return o;
            2: return !a;
            3: return !o;
            4: return x;
            5: return !x;
            default: return !o;
        endcase
    endfunction

    // Model of the gate under test; mode 8 is a stuck-at-0 output.
    function automatic logic gate_out(input int g, input logic [7:0] v, input int n);
        if (g == 8) return 1'b0;
        return gold(g, v, n);
    endfunction

    assign dut_s_a = gate_out(gate_a, 8'(vec_a), 2);
    assign dut_s_b = gate_out(gate_b, 8'(vec_b), 3);
    assign dut_s_c = gate_out(gate_c, 8'(vec_c), 2);

    gate_sweep_checker #(.N(2), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .dut_s(dut_s_a),
        .vec(vec_a), .exp_s(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_valid(fval_a), .first_err_vec(fvec_a));

    gate_sweep_checker #(.N(3), .SETTLE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .dut_s(dut_s_b),
        .vec(vec_b), .exp_s(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_valid(fval_b), .first_err_vec(fvec_b));

    gate_sweep_checker #(.N(2), .SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op(op_c), .dut_s(dut_s_c),
        .vec(vec_c), .exp_s(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_valid(fval_c), .first_err_vec(fvec_c));

    function automatic obs_t obs(input int inst);
        obs_t o;
        o = '0;
        case (inst)
            0: begin
                o.vec = 8'(vec_a); o.exp_s = exp_a; o.busy = busy_a; o.done = done_a;
                o.pass = pass_a; o.err = 9'(err_a); o.fvalid = fval_a; o.fvec = 8'(fvec_a);
            end
            1: begin
                o.vec = 8'(vec_b); o.exp_s = exp_b; o.busy = busy_b; o.done = done_b;
                o.pass = pass_b; o.err = 9'(err_b); o.fvalid = fval_b; o.fvec = 8'(fvec_b);
            end
            default: begin
                o.vec = 8'(vec_c); o.exp_s = exp_c; o.busy = busy_c; o.done = done_c;
                o.pass = pass_c; o.err = 9'(err_c); o.fvalid = fval_c; o.fvec = 8'(fvec_c);
            end
        endcase
        return o;
    endfunction

    task automatic set_start(input int inst, input logic val);
        case (inst)
            0:       start_a = val;
            1:       start_b = val;
            default: start_c = val;
        endcase
    endtask

    task automatic set_cfg(input int inst, input logic [2:0] op, input int gate);
        case (inst)
            0:       begin op_a = op; gate_a = gate; end
            1:       begin op_b = op; gate_b = gate; end
            default: begin op_c = op; gate_c = gate; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Runs one sweep. Expected per-cycle values are queued up front and
    // popped as the DUT steps. stray: cycle index at which a start pulse is
    // driven mid-sweep (-1 none). abort_at: cycle index at which reset is
    // pulsed and the sweep abandoned (-1 none).
    task automatic sweep(input string name, input int inst, input int n, input int settle,
                         input logic [2:0] op, input int gate, input int stray,
                         input int abort_at);
        step_t      q[$];
        step_t      s;
        obs_t       o;
        int         errs;
        logic       fvalid;
        logic [7:0] fv;
        int         total;
        errs = 0; fvalid = 1'b0; fv = '0;
        for (int v = 0; v < (1 << n); v++) begin
            for (int c = 0; c <= settle; c++)
                q.push_back('{v: 8'(v), e: gold(int'(op), 8'(v), n),
                              err: 9'(errs), fvalid: fvalid});
            if (gate_out(gate, 8'(v), n) !== gold(int'(op), 8'(v), n)) begin
                errs++;
                if (!fvalid) begin fvalid = 1'b1; fv = 8'(v); end
            end
        end
        total = q.size();

        @(negedge clk);
        set_cfg(inst, op, gate);
        set_start(inst, 1'b1);
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            set_start(inst, k == stray);
            s = q.pop_front();
            o = obs(inst);
            chk({name, " vec"},    64'(o.vec),    64'(s.v));
            chk({name, " exp_s"},  64'(o.exp_s),  64'(s.e));
            chk({name, " busy"},   64'(o.busy),   64'd1);
            chk({name, " done"},   64'({o.done, o.pass}), 64'd0);
            chk({name, " err"},    64'(o.err),    64'(s.err));
            chk({name, " fvalid"}, 64'(o.fvalid), 64'(s.fvalid));
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                set_start(inst, 1'b0);
                o = obs(inst);
                chk({name, " abort_zero"}, 64'(o), 64'd0);
                return;
            end
        end
        @(negedge clk);
        set_start(inst, 1'b0);
        o = obs(inst);
        chk({name, " end_done"},   64'({o.done, o.busy}), 64'b10);
        chk({name, " end_pass"},   64'(o.pass),   64'(errs == 0));
        chk({name, " end_err"},    64'(o.err),    64'(errs));
        chk({name, " end_fvalid"}, 64'(o.fvalid), 64'(fvalid));
        chk({name, " end_fvec"},   64'(o.fvec),   64'(fv));
        chk({name, " end_vec"},    64'(o.vec),    64'((1 << n) - 1));
    endtask

    initial begin
        obs_t o;

        // Reset held with start asserted: reset wins.
        rst_n   = 1'b0;
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_state", 64'(obs(i)), 64'd0);
        start_a = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("idle_hold", 64'(obs(0)), 64'd0);

        sweep("a_nor_ok",    0, 2, 1, 3'd3, 3, -1, -1);
        sweep("a_nor_and",   0, 2, 1, 3'd3, 0, -1, -1);
        repeat (3) @(negedge clk);
        o = obs(0);
        chk("done_hold", 64'({o.done, o.pass, o.err, o.fvalid, o.vec}),
            64'({1'b1, 1'b0, 9'd2, 1'b1, 8'd3}));
        sweep("a_nand_rerun", 0, 2, 1, 3'd2, 2, -1, -1);

        sweep("b_xor_stuck", 1, 3, 1, 3'd4, 8, -1, -1);
        sweep("b_rsvd_nor",  1, 3, 1, 3'd7, 3, -1, -1);

        sweep("c_and_settle3", 2, 2, 3, 3'd0, 0, 4, -1);

        sweep("a_abort", 0, 2, 1, 3'd3, 3, -1, 4);
        @(negedge clk);
        chk("post_abort_idle", 64'(obs(0)), 64'd0);
        sweep("a_or_after_abort", 0, 2, 1, 3'd1, 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
